// File: rtl/spi_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_module
// Purpose  : SPI mode-0 slave byte receiver. Oversamples the host's SCLK,
//            MOSI and CS_N on the system clock, shifts MOSI in MSB first on
//            each selected SCLK rise and presents each complete byte with a
//            stretched ready strobe for the downstream data dispatcher.
// Ports    : clk          system clock (single domain)
//            reset        asynchronous active-low reset
//            clk_en       clock enable; all state advances only when high
//            sclk         SPI clock from host (asynchronous)
//            mosi         SPI data from host (asynchronous)
//            cs_n         SPI chip select, active low (asynchronous)
//            buff_rx_spi  last complete byte, stable while rdy is high
//            rdy          high for RDY_HOLD enabled cycles per byte
//            overrun      sticky, set when a byte lands while rdy is high;
//                         cleared by a chip-select rising edge
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_module #(
    parameter int RDY_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic [7:0] buff_rx_spi,
    output logic       rdy,
    output logic       overrun
);

    // The hold counter is loaded with RDY_HOLD-1 so that rdy is high for
    // exactly RDY_HOLD enabled cycles (load cycle plus RDY_HOLD-1 decrements).
    localparam logic [7:0] c_HOLD_LOAD = 8'(RDY_HOLD - 1);
    localparam logic [2:0] c_LAST_BIT  = 3'd7;

    // ------------------------------------------------------------------------
    // Input synchronisers: two flops per asynchronous input, plus one extra
    // history flop for sclk and cs_n so their rising edges can be detected.
    // ------------------------------------------------------------------------
    logic r_sclk_meta;
    logic r_sclk_sync;
    logic r_sclk_prev;
    logic r_mosi_meta;
    logic r_mosi_sync;
    logic r_cs_meta;
    logic r_cs_sync;
    logic r_cs_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else if (clk_en) begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
            r_cs_meta   <= cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection and qualified events
    // ------------------------------------------------------------------------
    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_selected;
    logic w_shift_evt;
    logic w_byte_done;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_selected  = ~r_cs_sync;
    // SCLK activity while deselected is ignored entirely.
    assign w_shift_evt = w_sclk_rise & w_selected;
    assign w_byte_done = w_shift_evt & (r_bit_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------------
    // Shift register and bit counter. Deselection wipes any partial byte so
    // the next select always starts on a byte boundary.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (clk_en) begin
            if (!w_selected) begin
                r_shift   <= 8'h00;
                r_bit_cnt <= 3'd0;
            end else if (w_shift_evt) begin
                r_shift   <= {r_shift[6:0], r_mosi_sync};
                // 3-bit counter wraps 7 -> 0 on the byte-completing bit.
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte delivery, rdy stretching and overrun flag. A new byte always takes
    // priority: it overwrites the buffer and restarts the hold with no low
    // gap on rdy. Deselection does not cut short a hold already running.
    // ------------------------------------------------------------------------
    logic [7:0] r_buff;
    logic       r_rdy;
    logic [7:0] r_hold_cnt;
    logic       r_overrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buff     <= 8'h00;
            r_rdy      <= 1'b0;
            r_hold_cnt <= 8'h00;
            r_overrun  <= 1'b0;
        end else if (clk_en) begin
            if (w_byte_done) begin
                r_buff     <= {r_shift[6:0], r_mosi_sync};
                r_rdy      <= 1'b1;
                r_hold_cnt <= c_HOLD_LOAD;
                if (r_rdy) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                if (r_rdy) begin
                    if (r_hold_cnt == 8'h00) begin
                        r_rdy <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'h01;
                    end
                end
                if (w_cs_rise) begin
                    r_overrun <= 1'b0;
                end
            end
        end
    end

    assign buff_rx_spi = r_buff;
    assign rdy         = r_rdy;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rx_module
// Purpose  : Self-checking bench for spi_rx_module. Two instances share one
//            SPI stimulus stream: one with a short rdy hold (4) and one with
//            a long hold (40) so that back-to-back bytes exercise overrun.
//            A transaction-level model (byte/deselect events with their
//            pin-to-output latency, and a per-instance hold countdown)
//            predicts buff_rx_spi, rdy and overrun on every enabled edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rx_module;

    localparam int c_HOLD_A = 4;
    localparam int c_HOLD_B = 40;

    logic clk;
    logic reset;
    logic clk_en;
    logic sclk;
    logic mosi;
    logic cs_n;

    logic [7:0] buf_a;
    logic       rdy_a;
    logic       ovr_a;
    logic [7:0] buf_b;
    logic       rdy_b;
    logic       ovr_b;

    spi_rx_module #(.RDY_HOLD(c_HOLD_A)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .buff_rx_spi (buf_a),
        .rdy         (rdy_a),
        .overrun     (ovr_a)
    );

    spi_rx_module #(.RDY_HOLD(c_HOLD_B)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .buff_rx_spi (buf_b),
        .rdy         (rdy_b),
        .overrun     (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        int         due;      // enabled edge at which the event takes effect
        bit         is_byte;  // 1: byte delivered, 0: chip-select rise
        logic [7:0] data;
    } evt_t;

    evt_t       evq[$];
    int         en_edges;
    int         hold_val[2];
    int         exp_rem[2];   // enabled cycles of rdy still to come
    logic [7:0] exp_buf[2];
    logic       exp_ovr[2];

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d observed=%02h expected=%02h", tag, en_edges, obs, exp);
        end
    endtask

    task automatic model_clear();
        evq.delete();
        for (int i = 0; i < 2; i++) begin
            exp_rem[i] = 0;
            exp_buf[i] = 8'h00;
            exp_ovr[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        check("buf_a", buf_a, exp_buf[0]);
        check("rdy_a", {7'd0, rdy_a}, {7'd0, (exp_rem[0] > 0)});
        check("ovr_a", {7'd0, ovr_a}, {7'd0, exp_ovr[0]});
        check("buf_b", buf_b, exp_buf[1]);
        check("rdy_b", {7'd0, rdy_b}, {7'd0, (exp_rem[1] > 0)});
        check("ovr_b", {7'd0, ovr_b}, {7'd0, exp_ovr[1]});
    endtask

    // One clock: advance the model on enabled edges, then sample #1 later.
    task automatic tick();
        bit         byte_now;
        bit         clr_now;
        logic [7:0] bdata;
        evt_t       keep[$];
        @(posedge clk);
        byte_now = 1'b0;
        clr_now  = 1'b0;
        bdata    = 8'h00;
        if (!reset) begin
            model_clear();
        end else if (clk_en) begin
            en_edges++;
            foreach (evq[j]) begin
                if (evq[j].due == en_edges) begin
                    if (evq[j].is_byte) begin
                        byte_now = 1'b1;
                        bdata    = evq[j].data;
                    end else begin
                        clr_now = 1'b1;
                    end
                end else begin
                    keep.push_back(evq[j]);
                end
            end
            evq = keep;
            for (int i = 0; i < 2; i++) begin
                if (byte_now) begin
                    if (exp_rem[i] > 0) exp_ovr[i] = 1'b1;
                    exp_buf[i] = bdata;
                    exp_rem[i] = hold_val[i];
                end else begin
                    if (exp_rem[i] > 0) exp_rem[i]--;
                    if (clr_now) exp_ovr[i] = 1'b0;
                end
            end
        end
        #1;
        check_all();
    endtask

    // Inputs change just after an enabled edge, so the synchronised value is
    // visible at the outputs three enabled edges later.
    task automatic send_bit(input logic b, input int half, input bit last, input logic [7:0] data);
        mosi = b;
        sclk = 1'b0;
        repeat (half) tick();
        sclk = 1'b1;
        if (last) evq.push_back('{due: en_edges + 3, is_byte: 1'b1, data: data});
        repeat (half) tick();
    endtask

    task automatic send_byte(input logic [7:0] data, input int half);
        for (int i = 7; i >= 0; i--) begin
            send_bit(data[i], half, (i == 0), data);
        end
    endtask

    task automatic select_dev();
        sclk = 1'b0;
        cs_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic deselect_dev();
        sclk = 1'b0;
        cs_n = 1'b1;
        evq.push_back('{due: en_edges + 3, is_byte: 1'b0, data: 8'h00});
        repeat (6) tick();
    endtask

    logic [7:0] frame[8];
    logic [7:0] d;

    initial begin
        vectors     = 0;
        miscompares = 0;
        en_edges    = 0;
        hold_val[0] = c_HOLD_A;
        hold_val[1] = c_HOLD_B;
        model_clear();
        frame = '{8'h55, 8'h80, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01};

        // Reset held with SPI pins toggling: everything stays zero.
        reset  = 1'b0;
        clk_en = 1'b1;
        cs_n   = 1'b0;
        sclk   = 1'b0;
        mosi   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            tick();
        end
        sclk = 1'b0;
        cs_n = 1'b1;
        tick();
        reset = 1'b1;

        // Deselected: SCLK toggles produce nothing.
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            mosi = 1'($urandom);
            repeat (3) tick();
            sclk = 1'b1;
            repeat (3) tick();
        end
        sclk = 1'b0;
        repeat (10) tick();

        // Single byte, 8 enabled cycles per bit.
        select_dev();
        send_byte(8'h55, 4);
        repeat (50) tick();

        // Full dispatcher frame in one chip-select window.
        for (int i = 0; i < 8; i++) send_byte(frame[i], 4);
        repeat (50) tick();
        deselect_dev();

        // Partial byte abort then a full byte.
        select_dev();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 3, 1'b0, 8'h00);
        deselect_dev();
        select_dev();
        send_byte(8'hA3, 3);
        repeat (50) tick();
        deselect_dev();

        // Back-to-back bytes at 4 cycles per bit: long-hold instance overruns.
        select_dev();
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        repeat (10) tick();
        deselect_dev();
        repeat (40) tick();

        // Randomised windows of bytes with random bit rates and gaps.
        for (int w = 0; w < 6; w++) begin
            select_dev();
            for (int n = 0; n < int'($urandom_range(4, 1)); n++) begin
                send_byte(8'($urandom), int'($urandom_range(5, 2)));
                repeat ($urandom_range(12, 0)) tick();
            end
            repeat ($urandom_range(30, 1)) tick();
            deselect_dev();
            repeat ($urandom_range(45, 2)) tick();
        end

        // Clock-enable gating mid-byte with SCLK static.
        d = 8'($urandom);
        select_dev();
        for (int i = 7; i >= 4; i--) send_bit(d[i], 3, 1'b0, d);
        clk_en = 1'b0;
        repeat (20) tick();
        clk_en = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(d[i], 3, (i == 0), d);
        repeat (10) tick();

        // Short asynchronous reset pulse mid-byte, between clock edges.
        d = 8'($urandom);
        for (int i = 7; i >= 5; i--) send_bit(d[i], 3, 1'b0, d);
        sclk = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all();
        #1 reset = 1'b1;
        repeat (3) tick();
        send_byte(8'hC6, 3);
        repeat (50) tick();
        deselect_dev();
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_rx_module.md
# spi_rx_module

SPI-mode-0 slave byte receiver that deserialises the host's MOSI stream into bytes and presents each complete byte with a ready strobe. It sits directly upstream of the SPI data dispatcher: `buff_rx_spi` and `rdy` feed the dispatcher's byte bus and ready input. The dispatcher's frame parser detects a rising `rdy` edge on `clk_en` cycles, so this block guarantees a clean, stretched `rdy` pulse and a byte value that holds stable while `rdy` is high.

## Interface
Parameters:
- `RDY_HOLD`, default 4: number of enabled cycles `rdy` stays high per byte; legal range 2..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset; acts regardless of `clk_en`.
- `clk_en`  in  1  clock enable; all state advances only on `clk` rising edges with `clk_en`=1.
- `sclk`  in  1  SPI clock from host, asynchronous to `clk`.
- `mosi`  in  1  SPI data from host, asynchronous.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `buff_rx_spi`  out  8  last complete received byte, MSB first on the wire.
- `rdy`  out  1  high for `RDY_HOLD` enabled cycles after each byte completes.
- `overrun`  out  1  sticky: a byte completed while `rdy` was still high.

## Operation
- Synchronisers: `sclk`, `mosi` and `cs_n` each pass through two flops (meta, sync) on enabled cycles. A third flop holds the previous `sclk` sync value and a fourth holds the previous `cs_n` sync value.
- Edge detection: `sclk_rise` = sync high and prev low. `cs_rise` = `cs_n` sync high and prev low.
- Selection: the block is selected when the `cs_n` sync value is 0. `sclk_rise` while unselected is ignored.
- Shift: on `sclk_rise` while selected, `shift <= {shift[6:0], mosi_sync}` and `bit_cnt` (3 bits) increments.
- Byte complete: on a selected `sclk_rise` with `bit_cnt`=7:
  - `buff_rx_spi <= {shift[6:0], mosi_sync}`.
  - `bit_cnt <= 0`.
  - `rdy <= 1` and `hold_cnt <= RDY_HOLD-1`.
  - If `rdy` was already 1, `overrun <= 1` and the new byte still overwrites `buff_rx_spi`. The hold restarts, and `rdy` stays high with no low gap.
- Rdy hold: while `rdy`=1 and no byte completes, `hold_cnt` decrements each enabled cycle. When `hold_cnt`=0, `rdy <= 0`.
- Deselect: `cs_rise`, or the `cs_n` sync value being 1, forces `bit_cnt <= 0` and `shift <= 0`, so a partial byte is discarded. `buff_rx_spi` and `rdy`/`hold_cnt` are unaffected, so a byte already delivered finishes its hold.
- Overrun clear: `cs_rise` clears `overrun`. If a byte completes and `cs_rise` occur in the same cycle, byte completion wins: the byte is delivered and `overrun` is updated per the byte-complete rule.
- Reset (`reset`=0): all outputs and internal state go to 0 immediately, including the synchroniser flops. `buff_rx_spi`=0, `rdy`=0, `overrun`=0, `bit_cnt`=0. Reset mid-byte discards the partial byte.
- `clk_en`=0: every register holds its value. Edges on `sclk` shorter than the enabled-cycle sampling are not detected, which is a host constraint, not an error.

## Timing
- Host constraint: `sclk` high and low phases each ≥ 2 enabled cycles. `mosi` stable ≥ 2 enabled cycles around each `sclk` rise. `cs_n` low ≥ 2 enabled cycles before the first `sclk` rise.
- Latency: an 8th `sclk` rise at the pin before enabled edge k is captured as follows:
  - meta at k, sync at k+1;
  - `buff_rx_spi` and `rdy` update at k+2.
  - That is 3 enabled edges of latency.
- `rdy` is high for exactly `RDY_HOLD` enabled cycles per isolated byte, then low for at least one enabled cycle before the next byte. This requires byte spacing ≥ `RDY_HOLD`+1 enabled cycles; shorter spacing sets `overrun`.
- `buff_rx_spi` is constant from the cycle `rdy` rises until the next byte completes.
- The dispatcher, with its two-stage edge detect, sees each isolated byte exactly once.

## Test plan
- Reset and idle: assert `reset`=0 with `sclk`/`mosi` toggling → `buff_rx_spi`=0x00, `rdy`=0, `overrun`=0. Release `reset` with `cs_n`=1 and toggle `sclk` 8× → `rdy` stays 0.
- Single byte: `cs_n`=0, shift 0x55 MSB first at 8 enabled cycles per bit, `RDY_HOLD`=4 → `buff_rx_spi`=0x55 exactly 3 enabled cycles after the 8th rise. `rdy` is high for exactly 4 enabled cycles.
- Full frame into the dispatcher: send 0x55,0x80,0x02,0x10,0x20,0x30,0x40,0x01 in one `cs_n` window → 8 `rdy` pulses, `overrun`=0. The dispatcher outputs lint=0x80, colorIdx=0x02, red=0x10, green=0x20, blue=0x30, white=0x40, mode=0x01.
- Partial byte abort: shift 5 bits, raise `cs_n`, lower it, then send 0xA3 → only one `rdy` pulse, `buff_rx_spi`=0xA3.
- Overrun: `RDY_HOLD`=8, send two bytes 0x11, 0x22 at 4 enabled cycles per bit (32-cycle spacing is fine). Then set `RDY_HOLD`=40 and repeat → second byte raises `overrun`=1, `buff_rx_spi`=0x22, `rdy` stays high with no gap. Raising `cs_n` clears `overrun`.
- `clk_en` gating and async reset: hold `clk_en`=0 for 20 cycles mid-byte with `sclk` static → state frozen, and the byte completes correctly after re-enable. Pulse `reset`=0 for less than one `clk` period mid-byte → outputs clear immediately, and the next full byte is received correctly.
